// File: rtl/obb_pkg.sv
// OBB state record, field widths and physics constants shared by the sequencer and its updater.
package obb_pkg;

    localparam int unsigned SIZE_W        = 8;
    localparam int unsigned INERTIA_W     = 16;
    localparam int unsigned INV_MASS_W    = 16;
    localparam int unsigned INV_INERTIA_W = 24;
    localparam int unsigned POS_W         = 24;
    localparam int unsigned VEL_W         = 24;
    localparam int unsigned ANGLE_W       = 11;
    localparam int unsigned OMEGA_W       = 11;

    // Position advances by velocity/8 per step.
    localparam int unsigned VEL_SHIFT     = 3;

    localparam logic signed [POS_W-1:0]   WORLD_BOUND = 24'sh400000;
    localparam logic signed [ANGLE_W-1:0] ANGLE_WRAP  = 11'sd804;

    typedef struct packed {
        logic [SIZE_W-1:0]          width;
        logic [SIZE_W-1:0]          height;
        logic [INERTIA_W-1:0]       inertia;
        logic [INV_MASS_W-1:0]      inv_mass;
        logic [INV_INERTIA_W-1:0]   inv_inertia;
        logic signed [POS_W-1:0]    pos_x;
        logic signed [POS_W-1:0]    pos_y;
        logic signed [VEL_W-1:0]    vel_x;
        logic signed [VEL_W-1:0]    vel_y;
        logic signed [ANGLE_W-1:0]  angle;
        logic signed [OMEGA_W-1:0]  omega;
    } obb_state_t;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        COMMIT,
        DONE
    } seq_state_t;

endpackage

// File: rtl/obb_updater.sv
// Combinational one-step OBB integrator: wall reflection, position advance and angle wrap.
module obb_updater
    import obb_pkg::*;
(
    input  obb_state_t prev,
    output obb_state_t next
);

    localparam logic signed [ANGLE_W:0] WRAP_EXT = (ANGLE_W + 1)'(ANGLE_WRAP);

    // Reverse velocity only when outside the world and still moving outward.
    function automatic logic signed [VEL_W-1:0] reflect(
        input logic signed [POS_W-1:0] pos,
        input logic signed [VEL_W-1:0] vel
    );
        logic outward;
        outward = (pos > WORLD_BOUND && !vel[VEL_W-1] && vel != '0) ||
                  (pos < -WORLD_BOUND && vel[VEL_W-1]);
        return outward ? -vel : vel;
    endfunction

    logic signed [VEL_W-1:0]   vel_x_n;
    logic signed [VEL_W-1:0]   vel_y_n;
    logic signed [ANGLE_W:0]   angle_sum;

    always_comb begin
        next      = prev;
        vel_x_n   = reflect(prev.pos_x, prev.vel_x);
        vel_y_n   = reflect(prev.pos_y, prev.vel_y);
        angle_sum = (ANGLE_W + 1)'($signed(prev.angle)) + (ANGLE_W + 1)'($signed(prev.omega));

        if (angle_sum >= WRAP_EXT) begin
            angle_sum = angle_sum - WRAP_EXT;
        end else if (angle_sum[ANGLE_W]) begin
            angle_sum = angle_sum + WRAP_EXT;
        end

        next.vel_x = vel_x_n;
        next.vel_y = vel_y_n;
        next.pos_x = prev.pos_x + POS_W'(vel_x_n >>> VEL_SHIFT);
        next.pos_y = prev.pos_y + POS_W'(vel_y_n >>> VEL_SHIFT);
        next.angle = angle_sum[ANGLE_W-1:0];
    end

endmodule

// File: rtl/obb_state_sequencer.sv
// Sweeps every OBB slot through obb_updater once per accepted frame_tick.
// Define OBB_LOAD_PORT_EN to add the host load port (ld_valid/ld_idx/ld_state/ld_ready).
module obb_state_sequencer
    import obb_pkg::*;
#(
    parameter int unsigned NUM_OBB = 8,
    parameter int unsigned IDX_W   = 3
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             frame_tick,
    output logic             busy,
    output logic             done,
    output logic             overrun,
    input  logic [IDX_W-1:0] rd_idx,
    output obb_state_t       rd_state
`ifdef OBB_LOAD_PORT_EN
    ,
    input  logic             ld_valid,
    input  logic [IDX_W-1:0] ld_idx,
    input  obb_state_t       ld_state,
    output logic             ld_ready
`endif
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_OBB - 1);

    seq_state_t       state;
    seq_state_t       next_state;
    logic [IDX_W-1:0] idx;
    logic [IDX_W-1:0] idx_next;
    logic             fetch_c;
    logic             commit_c;
    logic             tick_accept_c;
    logic             tick_drop_c;

    obb_state_t       slots [NUM_OBB];
    obb_state_t       prev_state;
    obb_state_t       upd_state;

    obb_updater u_updater (
        .prev (prev_state),
        .next (upd_state)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            idx   <= '0;
        end else begin
            state <= next_state;
            idx   <= idx_next;
        end
    end

    always_comb begin
        next_state    = state;
        idx_next      = idx;
        fetch_c       = 1'b0;
        commit_c      = 1'b0;
        tick_accept_c = 1'b0;
        tick_drop_c   = 1'b0;
        case (state)
            IDLE: begin
                if (frame_tick) begin
                    tick_accept_c = 1'b1;
                    idx_next      = '0;
                    next_state    = FETCH;
                end
            end
            FETCH: begin
                fetch_c    = 1'b1;
                next_state = COMMIT;
            end
            COMMIT: begin
                commit_c = 1'b1;
                if (idx == LAST_IDX) begin
                    next_state = DONE;
                end else begin
                    idx_next   = idx + IDX_W'(1);
                    next_state = FETCH;
                end
            end
            DONE: begin
                idx_next   = '0;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
        if (state != IDLE) begin
            tick_drop_c = frame_tick;
        end
    end

    // done trails the DONE state by one cycle so it lands 2*NUM_OBB+1 edges after the tick.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            busy    <= 1'b0;
            done    <= 1'b0;
            overrun <= 1'b0;
        end else begin
            busy <= (next_state != IDLE);
            done <= (state == DONE);
            if (tick_accept_c) begin
                overrun <= 1'b0;
            end else if (tick_drop_c) begin
                overrun <= 1'b1;
            end
        end
    end

`ifdef OBB_LOAD_PORT_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ld_ready <= 1'b1;
        end else begin
            ld_ready <= (next_state == IDLE);
        end
    end
`endif

    // A load lands at the tick edge, so the first FETCH of that sweep already sees it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < NUM_OBB; i++) begin
                slots[i] <= '0;
            end
            prev_state <= '0;
            rd_state   <= '0;
        end else begin
            rd_state <= slots[rd_idx];
            if (fetch_c) begin
                prev_state <= slots[idx];
            end
            if (commit_c) begin
                slots[idx] <= upd_state;
            end
`ifdef OBB_LOAD_PORT_EN
            if (ld_valid && ld_ready) begin
                slots[ld_idx] <= ld_state;
            end
`endif
        end
    end

endmodule

// File: doc/obb_state_sequencer.md
OBB_STATE_SEQUENCER -- requirements
Module: obb_state_sequencer

Interface
REQ-001 Parameter NUM_OBB, default 8, SHALL set the number of OBB slots held (legal range 1..64).
REQ-002 Parameter IDX_W, default 3, SHALL set the index width (clog2 of NUM_OBB, minimum 1).
REQ-003 clk  in  1: the single clock; all logic SHALL be rising-edge.
REQ-004 reset_n  in  1: the reset, asynchronous and active-low.
REQ-005 frame_tick  in  1: single-cycle request to advance every OBB by one step.
REQ-006 busy  out  1: high while a sweep is in progress.
REQ-007 done  out  1: single-cycle pulse when a sweep completes.
REQ-008 overrun  out  1: sticky flag, set when a frame_tick is dropped.
REQ-009 rd_idx  in  IDX_W: renderer read index.
REQ-010 rd_state  out  obb_state_t: registered state of slot rd_idx.
REQ-011 ld_valid  in  1, ld_idx in IDX_W, ld_state in obb_state_t: host load port.
REQ-012 ld_ready  out  1: load acceptance (only when REQ-028 is compiled in).

Function
REQ-013 The block SHALL own an array of NUM_OBB obb_state_t registers.
REQ-014 obb_state_t fields SHALL be:
- width 8, height 8
- inertia 16, inv_mass 16, inv_inertia 24
- signed pos_x/pos_y/vel_x/vel_y 24 each
- signed angle 11, omega 11
REQ-015 The FSM SHALL have the states IDLE, FETCH, COMMIT and DONE.
REQ-016 In IDLE, frame_tick SHALL move the FSM to FETCH with index 0 and clear overrun.
REQ-017 FETCH SHALL register slot[index] into a prev-state register and go to COMMIT.
REQ-018 COMMIT SHALL write the updater's next-state output to slot[index].
- If index equals NUM_OBB-1, the FSM SHALL go to DONE.
- Otherwise it SHALL increment the index and return to FETCH.
REQ-019 DONE SHALL assert done for one cycle and return to IDLE.
REQ-020 busy SHALL be high in FETCH, COMMIT and DONE.
REQ-021 Latency: with frame_tick sampled at edge T, done SHALL be high in the cycle after edge T+2*NUM_OBB+1.
REQ-022 A frame_tick arriving while busy SHALL be ignored and SHALL set overrun.
- overrun SHALL be held until the next accepted frame_tick.
REQ-023 rd_state SHALL equal slot[rd_idx] one cycle after rd_idx is sampled.
- A read of the slot being committed in the same cycle SHALL return the pre-commit value.
REQ-024 Each slot SHALL be updated exactly once per sweep; the index SHALL not wrap within a sweep.
REQ-025 All arithmetic SHALL be performed by the sub-module; this block SHALL not alter field widths.

Reset
REQ-026 When reset_n is low:
- busy, done and overrun SHALL be 0.
- The FSM SHALL be in IDLE with index 0.
- All slots, the prev-state register and rd_state SHALL be 0.
REQ-027 Reset asserted mid-sweep SHALL abort the sweep without a done pulse; slots SHALL clear to 0.

Configuration
REQ-028 Macro OBB_LOAD_PORT_EN SHALL compile the load port in or out.
- Defined: ld_ready = (state==IDLE); ld_valid && ld_ready SHALL write ld_state to slot[ld_idx] at the next edge.
- Defined: a frame_tick and a load in the same IDLE cycle SHALL apply the load first; the sweep SHALL then see the loaded value.
- Not defined: ld_valid, ld_idx and ld_state SHALL be absent, ld_ready SHALL be absent, and slots SHALL hold reset values until updated.

Structure
REQ-029 Package obb_pkg SHALL hold the following; the block SHALL not redefine them:
- obb_state_t
- the field width constants
- the world bound 24'h400000
- the angle wrap constant 11'd804
REQ-030 The existing combinational next-state sub-module obb_updater SHALL be instantiated once, driven from the prev-state register.

Verification
REQ-031 Reset mid-sweep: assert reset_n low while busy -> busy=0, no done pulse, all slots and rd_state read 0.
REQ-032 Single step, NUM_OBB=8: load slot 0 with pos_x=0x001000, vel_x=0x000080, angle=10, omega=5; pulse frame_tick -> done at cycle 18; slot 0 reads pos_x=0x001010, angle=15.
REQ-033 Wall bounce: load pos_x=0x400010, vel_x=0x000040; sweep -> vel_x=0xFFFFC0 and pos_x=0x400008.
REQ-034 Angle wrap: load angle=800, omega=10; sweep -> angle=6.
REQ-035 Overrun: second frame_tick at cycle 5 of a sweep -> overrun=1, exactly one done pulse, each slot stepped once; next accepted tick clears overrun.
REQ-036 Load/tick collision (OBB_LOAD_PORT_EN defined): ld_valid and frame_tick in the same IDLE cycle -> the sweep output reflects the loaded state.
